stdio_bridge: RTL and testbench



---
 rtl/stdio_bridge_pkg.sv | 9 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/stdio_bridge.sv | 127 ++++++++++++
 tb/tb_stdio_bridge.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdio_bridge_pkg.sv
// Shared constants for the stdio bridge: TX sequencer state encodings.
package stdio_bridge_pkg;

  localparam logic [1:0] TXS_IDLE      = 2'd0;
  localparam logic [1:0] TXS_START     = 2'd1;
  localparam logic [1:0] TXS_WAIT_BUSY = 2'd2;
  localparam logic [1:0] TXS_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers and an occupancy count.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr_reg;
  logic [DEPTH_LOG2:0] rptr_reg;
  logic                do_push;
  logic                do_pop;

  assign level   = wptr_reg - rptr_reg;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (wptr_reg == rptr_reg);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is dropped.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_reg[DEPTH_LOG2-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + 1'b1;
      if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
    end
  end

  // Asynchronous read gives show-ahead; the head reads as zero while empty.
  assign dout = empty ? '0 : mem[rptr_reg[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/stdio_bridge.sv
// Buffered bridge between the core's stdout/stdin handshakes and the UART TX/RX blocks.
module stdio_bridge
  import stdio_bridge_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        out_data,
  input  logic                     out_valid,
  output logic                     out_ready,
  output logic [DATA_W-1:0]        in_data,
  output logic                     in_valid,
  input  logic                     in_ready,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_ready,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_strobe,
  output logic [TX_DEPTH_LOG2:0]   tx_level,
  output logic [RX_DEPTH_LOG2:0]   rx_level,
  output logic                     rx_overrun
);

  logic              tx_full;
  logic              tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic              tx_pop;
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [DATA_W-1:0] tx_data_reg;
  logic              rx_overrun_reg;

  assign out_ready = !tx_full;

  sync_fifo #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_valid),
    .din   (out_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  assign tx_pop = (state_reg == TXS_IDLE) && !tx_empty && tx_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TXS_IDLE:      if (tx_pop) state_next = TXS_START;
      TXS_START:     state_next = TXS_WAIT_BUSY;
      TXS_WAIT_BUSY: if (!tx_ready) state_next = TXS_WAIT_DONE;
      TXS_WAIT_DONE: if (tx_ready) state_next = TXS_IDLE;
      default:       state_next = TXS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= TXS_IDLE;
      tx_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (tx_pop) tx_data_reg <= tx_head;
    end
  end

  assign tx_start   = (state_reg == TXS_START);
  assign tx_data    = tx_data_reg;
  assign rx_overrun = rx_overrun_reg;

  generate
    if (RX_DEPTH_LOG2 > 0) begin : g_rx
      logic rx_full;
      logic rx_empty;

      sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
      ) rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_strobe),
        .din   (rx_data),
        .pop   (in_ready),
        .dout  (in_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
      );

      assign in_valid = !rx_empty;

      always_ff @(posedge clk) begin
        if (reset) begin
          rx_overrun_reg <= 1'b0;
        end else if (rx_strobe && rx_full) begin
          rx_overrun_reg <= 1'b1;
        end
      end
    end else begin : g_no_rx
      // Without a stdin buffer every received byte is lost, so each strobe is an overrun.
      logic unused_rx;
      assign unused_rx = ^{in_ready, rx_data};
      assign in_valid  = 1'b0;
      assign in_data   = '0;
      assign rx_level  = '0;

      always_ff @(posedge clk) begin
        if (reset) begin
          rx_overrun_reg <= 1'b0;
        end else if (rx_strobe) begin
          rx_overrun_reg <= 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_stdio_bridge.sv
// Scoreboard bench for stdio_bridge: directed TX/RX traffic against a 10-cycle-busy UART model.
module tb_stdio_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [4:0] tx_level;
  logic [4:0] rx_level;
  logic       rx_overrun;

  logic       uart_hold = 1'b0;
  int         busy_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         start_count = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  stdio_bridge #(
    .DATA_W        (8),
    .TX_DEPTH_LOG2 (4),
    .RX_DEPTH_LOG2 (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe),
    .tx_level   (tx_level),
    .rx_level   (rx_level),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for 10 cycles after each start pulse, ignores bridge reset.
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_ready = !uart_hold && (busy_cnt == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired, got timeout, expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_drain(input string name);
    int i;
    for (i = 0; i < 600 && tx_level != 0; i++) tick();
    if (tx_level != 0) timeout(name);
    repeat (20) tick();
    check(name, txq.size(), 0);
  endtask

  // Monitor: pops the expected queues whenever the DUT presents a byte.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (reset) begin
      txq.delete();
      rxq.delete();
    end else begin
      if (tx_start) begin
        start_count++;
        if (txq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_start_unexpected: got tx_data 0x%0h, expected no pulse", tx_data);
        end else begin
          exp_b = txq.pop_front();
          check("tx_byte", {24'h0, tx_data}, {24'h0, exp_b});
        end
      end
      if (in_valid && in_ready) begin
        if (rxq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_pop_unexpected: got in_data 0x%0h, expected empty", in_data);
        end else begin
          exp_b = rxq.pop_front();
          check("rx_byte", {24'h0, in_data}, {24'h0, exp_b});
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_out_ready"},  out_ready, 1);
    check({tag, "_in_valid"},   in_valid, 0);
    check({tag, "_in_data"},    in_data, 0);
    check({tag, "_tx_start"},   tx_start, 0);
    check({tag, "_tx_data"},    tx_data, 0);
    check({tag, "_tx_level"},   tx_level, 0);
    check({tag, "_rx_level"},   rx_level, 0);
    check({tag, "_rx_overrun"}, rx_overrun, 0);
  endtask

  initial begin
    int i;
    int base;
    reset     = 1'b1;
    out_data  = 8'h00;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    rx_data   = 8'h00;
    rx_strobe = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_values("reset");
    tick();
    reset = 1'b0;
    tick();

    // Two back-to-back bytes, 2-cycle write-to-start latency.
    out_valid = 1'b1;
    out_data  = 8'h48;
    txq.push_back(8'h48);
    tick();
    out_data = 8'h69;
    txq.push_back(8'h69);
    @(negedge clk);
    check("lat_start_n", tx_start, 0);
    check("lat_level_n", tx_level, 1);
    tick();
    out_valid = 1'b0;
    @(negedge clk);
    check("lat_start_n1", tx_start, 1);
    check("lat_level_n1", tx_level, 1);
    wait_tx_drain("hi_drain");
    check("hi_level_end", tx_level, 0);

    // Fill TX FIFO while UART is held busy; 17th byte waits for the first pop.
    uart_hold = 1'b1;
    for (i = 0; i < 16; i++) begin
      out_valid = 1'b1;
      out_data  = 8'hA0 + 8'(i);
      txq.push_back(out_data);
      tick();
    end
    out_data = 8'hB0;
    @(negedge clk);
    check("full_out_ready", out_ready, 0);
    check("full_tx_level", tx_level, 16);
    tick();
    tick();
    @(negedge clk);
    check("full_hold_level", tx_level, 16);
    uart_hold = 1'b0;
    for (i = 0; i < 20 && !out_ready; i++) tick();
    if (!out_ready) timeout("full_release");
    txq.push_back(8'hB0);
    tick();
    out_valid = 1'b0;
    @(negedge clk);
    check("full_17th_level", tx_level, 16);
    wait_tx_drain("full_drain");

    // Three stdin bytes held, then consumed in order.
    rx_strobe = 1'b1;
    rx_data   = 8'h2B;
    rxq.push_back(8'h2B);
    tick();
    rx_data = 8'h2C;
    rxq.push_back(8'h2C);
    @(negedge clk);
    check("rx_lat_valid", in_valid, 1);
    check("rx_lat_data", in_data, 8'h2B);
    tick();
    rx_data = 8'h2E;
    rxq.push_back(8'h2E);
    tick();
    rx_strobe = 1'b0;
    @(negedge clk);
    check("rx3_level", rx_level, 3);
    check("rx3_head", in_data, 8'h2B);
    for (i = 0; i < 3; i++) begin
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      tick();
    end
    @(negedge clk);
    check("rx3_in_valid", in_valid, 0);
    check("rx3_level_end", rx_level, 0);
    check("rx3_queue", rxq.size(), 0);

    // Overrun: full RX FIFO drops 0xFF, then strobe+pop while full also drops.
    for (i = 0; i < 16; i++) begin
      rx_strobe = 1'b1;
      rx_data   = 8'h10 + 8'(i);
      rxq.push_back(rx_data);
      tick();
    end
    rx_strobe = 1'b0;
    @(negedge clk);
    check("ovr_level_full", rx_level, 16);
    check("ovr_flag_clear", rx_overrun, 0);
    rx_strobe = 1'b1;
    rx_data   = 8'hFF;
    tick();
    rx_strobe = 1'b0;
    @(negedge clk);
    check("ovr_flag_set", rx_overrun, 1);
    check("ovr_level_kept", rx_level, 16);
    check("ovr_head_kept", in_data, 8'h10);
    rx_strobe = 1'b1;
    rx_data   = 8'hEE;
    in_ready  = 1'b1;
    tick();
    rx_strobe = 1'b0;
    in_ready  = 1'b0;
    @(negedge clk);
    check("ovr_simul_level", rx_level, 15);
    check("ovr_simul_head", in_data, 8'h11);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("ovr_rst_flag", rx_overrun, 0);
    check("ovr_rst_level", rx_level, 0);
    check("ovr_rst_valid", in_valid, 0);
    tick();
    reset = 1'b0;
    tick();

    // Reset during WAIT_DONE with 5 bytes still queued.
    for (i = 0; i < 6; i++) begin
      out_valid = 1'b1;
      out_data  = 8'h30 + 8'(i);
      txq.push_back(out_data);
      tick();
    end
    out_valid = 1'b0;
    for (i = 0; i < 50 && tx_ready; i++) tick();
    if (tx_ready) timeout("mid_busy");
    tick();
    tick();
    @(negedge clk);
    check("mid_tx_level", tx_level, 5);
    base  = start_count;
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_reset_values("mid_rst");
    tick();
    reset = 1'b0;
    repeat (40) tick();
    check("mid_no_restart", start_count, base);
    check("mid_level_after", tx_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
